// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: ALU command codes, shifter types,
// multiplier FSM encoding and a rotate helper.
package exe_stage_pkg;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MUL = 4'b1010;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_BUSY = 2'b01,
    MUL_DONE = 2'b10
  } mul_state_e;

  // One partial product per BUSY cycle; counter runs 31 down to 0.
  localparam logic [4:0] MUL_COUNT_INIT = 5'd31;

  function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] amt);
    logic [63:0] dbl;
    dbl = {v, v} >> amt;
    return dbl[31:0];
  endfunction

endpackage

// File: rtl/exe_stage_mul_iter.sv
// Iterative radix-2 shift-add multiplier returning the low 32 bits of a*b.
// start/busy/done handshake; operands are latched on start.
module mul_iter
  import exe_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] product_o
);

  mul_state_e  state_q;
  logic [4:0]  count_q;
  logic [31:0] mcand_q;
  logic [31:0] mplier_q;
  logic [31:0] acc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= MUL_IDLE;
      count_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      case (state_q)
        MUL_IDLE: begin
          if (start_i) begin
            mcand_q  <= a_i;
            mplier_q <= b_i;
            acc_q    <= '0;
            count_q  <= MUL_COUNT_INIT;
            state_q  <= MUL_BUSY;
            busy_o   <= 1'b1;
          end
        end
        MUL_BUSY: begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          count_q  <= count_q - 5'd1;
          if (count_q == 5'd0) begin
            state_q <= MUL_DONE;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
          end
        end
        MUL_DONE: begin
          // The ID register advances on this edge, so IDLE sees a fresh instruction.
          state_q <= MUL_IDLE;
          done_o  <= 1'b0;
        end
        default: begin
          state_q <= MUL_IDLE;
          busy_o  <= 1'b0;
          done_o  <= 1'b0;
        end
      endcase
    end
  end

  assign product_o = acc_q;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: Val2 shifter, single-cycle ALU with NZCV generation, branch
// target adder, and a stall interface around the iterative multiplier.
module exe_stage
  import exe_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  exe_cmd_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        s_in,
  input  logic        imm_in,
  input  logic [11:0] shift_operand_in,
  input  logic [31:0] val_rn_in,
  input  logic [31:0] val_rm_in,
  input  logic [3:0]  status_in,
  input  logic [31:0] pc_in,
  input  logic [23:0] signed_imm24_in,
  output logic [31:0] alu_result,
  output logic [3:0]  status_bits_out,
  output logic        status_write,
  output logic [31:0] branch_addr,
  output logic        stall_out,
  output logic        result_valid
);

  logic        mem_access;
  logic        is_mul;
  logic        mul_busy;
  logic        mul_done;
  logic [31:0] mul_product;

  logic [31:0] val2;
  logic [31:0] imm_rot;
  logic [31:0] rm_shifted;
  logic [4:0]  shamt;

  logic [31:0] result;
  logic [31:0] opb;
  logic        cin;
  logic [32:0] arith_sum;
  logic        flag_c;
  logic        flag_v;
  logic        keep_flags;

  assign mem_access = mem_read_in | mem_write_in;
  assign is_mul     = (exe_cmd_in == CMD_MUL) && !mem_access;

  mul_iter u_mul_iter (
    .clk       (clk),
    .rst       (rst),
    .start_i   (is_mul),
    .a_i       (val_rn_in),
    .b_i       (val_rm_in),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  // Stall covers the presentation cycle in IDLE plus every BUSY cycle.
  assign stall_out    = !rst && (mul_busy || (is_mul && !mul_done));
  assign result_valid = !stall_out;
  assign status_write = s_in & result_valid;

  assign shamt   = shift_operand_in[11:7];
  assign imm_rot = ror32({24'b0, shift_operand_in[7:0]}, {shift_operand_in[11:8], 1'b0});

  always_comb begin
    rm_shifted = val_rm_in;
    case (shift_operand_in[6:5])
      SH_LSL:  rm_shifted = val_rm_in << shamt;
      SH_LSR:  rm_shifted = val_rm_in >> shamt;
      SH_ASR:  rm_shifted = $unsigned($signed(val_rm_in) >>> shamt);
      default: rm_shifted = ror32(val_rm_in, shamt);
    endcase
  end

  always_comb begin
    if (mem_access)  val2 = {20'b0, shift_operand_in};
    else if (imm_in) val2 = imm_rot;
    else             val2 = rm_shifted;
  end

  always_comb begin
    result     = '0;
    opb        = val2;
    cin        = 1'b0;
    arith_sum  = '0;
    flag_c     = status_in[1];
    flag_v     = status_in[0];
    keep_flags = 1'b0;
    if (mem_access) begin
      result = val_rn_in + val2;
    end else begin
      case (exe_cmd_in)
        CMD_MOV: result = val2;
        CMD_MVN: result = ~val2;
        CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: begin
          // Subtraction is Rn + ~Val2 + cin, so the carry-out is NOT borrow.
          opb = ((exe_cmd_in == CMD_SUB) || (exe_cmd_in == CMD_SBC)) ? ~val2 : val2;
          case (exe_cmd_in)
            CMD_ADD: cin = 1'b0;
            CMD_SUB: cin = 1'b1;
            default: cin = status_in[1];
          endcase
          arith_sum = {1'b0, val_rn_in} + {1'b0, opb} + {32'b0, cin};
          result    = arith_sum[31:0];
          flag_c    = arith_sum[32];
          flag_v    = (val_rn_in[31] == opb[31]) && (result[31] != val_rn_in[31]);
        end
        CMD_AND: result = val_rn_in & val2;
        CMD_ORR: result = val_rn_in | val2;
        CMD_EOR: result = val_rn_in ^ val2;
        CMD_MUL: result = mul_product;
        default: begin
          result     = '0;
          keep_flags = 1'b1;
        end
      endcase
    end
  end

  assign alu_result      = result;
  assign status_bits_out = keep_flags ? status_in
                                      : {result[31], (result == 32'd0), flag_c, flag_v};

  assign branch_addr = pc_in + {{6{signed_imm24_in[23]}}, signed_imm24_in, 2'b00};

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: directed vectors push expectations, a
// negedge monitor pops and compares whenever a result is presented.
module tb_exe_stage;

  logic        clk;
  logic        rst;
  logic [3:0]  exe_cmd_in;
  logic        mem_read_in;
  logic        mem_write_in;
  logic        s_in;
  logic        imm_in;
  logic [11:0] shift_operand_in;
  logic [31:0] val_rn_in;
  logic [31:0] val_rm_in;
  logic [3:0]  status_in;
  logic [31:0] pc_in;
  logic [23:0] signed_imm24_in;
  logic [31:0] alu_result;
  logic [3:0]  status_bits_out;
  logic        status_write;
  logic [31:0] branch_addr;
  logic        stall_out;
  logic        result_valid;

  exe_stage dut (
    .clk              (clk),
    .rst              (rst),
    .exe_cmd_in       (exe_cmd_in),
    .mem_read_in      (mem_read_in),
    .mem_write_in     (mem_write_in),
    .s_in             (s_in),
    .imm_in           (imm_in),
    .shift_operand_in (shift_operand_in),
    .val_rn_in        (val_rn_in),
    .val_rm_in        (val_rm_in),
    .status_in        (status_in),
    .pc_in            (pc_in),
    .signed_imm24_in  (signed_imm24_in),
    .alu_result       (alu_result),
    .status_bits_out  (status_bits_out),
    .status_write     (status_write),
    .branch_addr      (branch_addr),
    .stall_out        (stall_out),
    .result_valid     (result_valid)
  );

  typedef struct {
    logic [31:0] res;
    logic [3:0]  nzcv;
    logic        sw;
    logic [31:0] br;
    int          stalls;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   stall_cnt = 0;
  logic tb_active = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && tb_active) begin
      if (stall_out) begin
        stall_cnt++;
      end else if (result_valid) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL scoreboard: result presented with empty queue, got 0x%08h", alu_result);
        end else begin
          mon_e = sb_q.pop_front();
          chk("alu_result", alu_result, mon_e.res);
          chk("nzcv", {28'b0, status_bits_out}, {28'b0, mon_e.nzcv});
          chk("status_write", {31'b0, status_write}, {31'b0, mon_e.sw});
          chk("branch_addr", branch_addr, mon_e.br);
          chk("stall_cycles", stall_cnt, mon_e.stalls);
          $display("txn res=0x%08h nzcv=%b sw=%b br=0x%08h stalls=%0d",
                   alu_result, status_bits_out, status_write, branch_addr, stall_cnt);
        end
        stall_cnt = 0;
      end
    end
  end

  task automatic drive(input logic [3:0] cmd, input logic mr, input logic mw, input logic s,
                       input logic imm, input logic [11:0] so, input logic [31:0] rn,
                       input logic [31:0] rm, input logic [3:0] st, input logic [31:0] pc,
                       input logic [23:0] i24);
    exe_cmd_in = cmd; mem_read_in = mr; mem_write_in = mw; s_in = s; imm_in = imm;
    shift_operand_in = so; val_rn_in = rn; val_rm_in = rm; status_in = st;
    pc_in = pc; signed_imm24_in = i24;
  endtask

  task automatic issue(input logic [3:0] cmd, input logic mr, input logic mw, input logic s,
                       input logic imm, input logic [11:0] so, input logic [31:0] rn,
                       input logic [31:0] rm, input logic [3:0] st, input logic [31:0] pc,
                       input logic [23:0] i24, input logic [31:0] e_res, input logic [3:0] e_nzcv,
                       input logic [31:0] e_br, input int e_stalls, input bit scramble);
    exp_t e;
    bit ok;
    drive(cmd, mr, mw, s, imm, so, rn, rm, st, pc, i24);
    e.res = e_res; e.nzcv = e_nzcv; e.sw = s; e.br = e_br; e.stalls = e_stalls;
    sb_q.push_back(e);
    tb_active = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (result_valid) begin
        ok = 1'b1;
        break;
      end
      if (scramble && c == 5) begin
        val_rn_in = 32'hDEADBEEF;
        val_rm_in = 32'h12345678;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout: result_valid never rose within 60 cycles, required 1");
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    // ADD 2 + imm 3 while in reset: outputs must follow inputs, no stall.
    drive(4'b0010, 0, 0, 1, 1, 12'h003, 32'd2, 32'd0, 4'b0000, 32'h100, 24'h0);
    #3;
    chk("rst_stall", {31'b0, stall_out}, 32'd0);
    chk("rst_valid", {31'b0, result_valid}, 32'd1);
    chk("rst_comb_result", alu_result, 32'd5);
    chk("rst_status_write", {31'b0, status_write}, 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // ADD overflow into sign bit
    issue(4'b0010, 0, 0, 1, 1, 12'h001, 32'h7FFFFFFF, 32'h0, 4'b0000, 32'h100, 24'h0,
          32'h80000000, 4'b1001, 32'h100, 0, 0);
    // SBC with C=0, negative branch offset
    issue(4'b0101, 0, 0, 1, 1, 12'h005, 32'd5, 32'h0, 4'b0000, 32'h200, 24'hFFFFFE,
          32'hFFFFFFFF, 4'b1000, 32'h1F8, 0, 0);
    // MOV rotated immediate, max positive branch offset
    issue(4'b0001, 0, 0, 0, 1, 12'h2FF, 32'h0, 32'h0, 4'b0011, 32'h0, 24'h7FFFFF,
          32'hF000000F, 4'b1011, 32'h01FFFFFC, 0, 0);
    // SUB reg-reg equal -> zero, no borrow
    issue(4'b0100, 0, 0, 1, 0, 12'h000, 32'd3, 32'd3, 4'b0000, 32'h100, 24'h0,
          32'h0, 4'b0110, 32'h100, 0, 0);
    // AND with Rm LSR #4
    issue(4'b0110, 0, 0, 1, 0, 12'h220, 32'hFF00FF00, 32'h0F0F0F0F, 4'b0010, 32'h100, 24'h0,
          32'h0000F000, 4'b0010, 32'h100, 0, 0);
    // EOR with Rm ASR #31
    issue(4'b1000, 0, 0, 1, 0, 12'hFC0, 32'h0000FFFF, 32'h80000000, 4'b0000, 32'h100, 24'h0,
          32'hFFFF0000, 4'b1000, 32'h100, 0, 0);
    // ORR with Rm ROR #8
    issue(4'b0111, 0, 0, 1, 0, 12'h460, 32'h1, 32'h000000AB, 4'b0001, 32'h100, 24'h0,
          32'hAB000001, 4'b1001, 32'h100, 0, 0);
    // ADD with Rm LSL #31
    issue(4'b0010, 0, 0, 1, 0, 12'hF80, 32'h1, 32'h1, 4'b0000, 32'h100, 24'h0,
          32'h80000001, 4'b1000, 32'h100, 0, 0);
    // ADC wraps to zero with carry out
    issue(4'b0011, 0, 0, 1, 1, 12'h000, 32'hFFFFFFFF, 32'h0, 4'b0010, 32'h100, 24'h0,
          32'h0, 4'b0110, 32'h100, 0, 0);
    // MVN of zero
    issue(4'b1001, 0, 0, 1, 1, 12'h000, 32'h0, 32'h0, 4'b0000, 32'h100, 24'h0,
          32'hFFFFFFFF, 4'b1000, 32'h100, 0, 0);
    // LDR: address add overrides command and imm flag
    issue(4'b0000, 1, 0, 0, 1, 12'hFFF, 32'h1000, 32'h0, 4'b0000, 32'h100, 24'h0,
          32'h00001FFF, 4'b0000, 32'h100, 0, 0);
    // STR with MUL command code: address add, no stall
    issue(4'b1010, 0, 1, 0, 1, 12'h004, 32'h20, 32'h5, 4'b0000, 32'h100, 24'h0,
          32'h00000024, 4'b0000, 32'h100, 0, 0);
    // Undefined command: zero result, flags unchanged
    issue(4'b1111, 0, 0, 1, 0, 12'h000, 32'h1234, 32'h5678, 4'b0101, 32'h100, 24'h0,
          32'h0, 4'b0101, 32'h100, 0, 0);
    // MUL 0x00010001^2
    issue(4'b1010, 0, 0, 1, 0, 12'h000, 32'h00010001, 32'h00010001, 4'b0011, 32'h100, 24'h0,
          32'h00020001, 4'b0011, 32'h100, 33, 0);

    // Abort a MUL with reset at cycle 10, not tracked by the scoreboard.
    tb_active = 1'b0;
    drive(4'b1010, 0, 0, 1, 0, 12'h000, 32'h55, 32'h77, 4'b0000, 32'h100, 24'h0);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_stall", {31'b0, stall_out}, 32'd0);
    chk("abort_valid", {31'b0, result_valid}, 32'd1);
    exe_cmd_in = 4'b0000;
    #1;
    chk("abort_comb_result", alu_result, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    issue(4'b1010, 0, 0, 0, 0, 12'h000, 32'd3, 32'd4, 4'b0000, 32'h100, 24'h0,
          32'd12, 4'b0100 & 4'b0000, 32'h100, 33, 0);

    // Back-to-back MULs, the second with operands changing mid-BUSY, then an ADD.
    issue(4'b1010, 0, 0, 1, 0, 12'h000, 32'd2, 32'd3, 4'b0000, 32'h100, 24'h0,
          32'd6, 4'b0000, 32'h100, 33, 0);
    issue(4'b1010, 0, 0, 1, 0, 12'h000, 32'd7, 32'd9, 4'b0000, 32'h100, 24'h0,
          32'd63, 4'b0000, 32'h100, 33, 1);
    issue(4'b0010, 0, 0, 1, 1, 12'h001, 32'd1, 32'h0, 4'b0000, 32'h100, 24'h0,
          32'd2, 4'b0000, 32'h100, 0, 0);

    tb_active = 1'b0;
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
